// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: IF/ID payload layout, NOP bubble and
// occupancy-state encoding used by the elastic stage register.
package pipe_pkg;

   localparam int PC_W    = 32;
   localparam int INSTR_W = 32;
   localparam int IFID_W  = PC_W + INSTR_W;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

   typedef struct packed {
      logic [PC_W-1:0]    pc_plus4;
      logic [INSTR_W-1:0] instr;
   } ifid_t;

   // Encoding equals the live-entry count, so the state drives occupancy directly.
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

   function automatic ifid_t make_ifid(input logic [PC_W-1:0] pc4,
                                       input logic [INSTR_W-1:0] ins);
      ifid_t p;
      p.pc_plus4 = pc4;
      p.instr    = ins;
      return p;
   endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready channel pair around one pipeline stage register.
// master = environment side (producer/consumer), slave = the stage itself.
interface pipe_stage_skid_if
   import pipe_pkg::*;
#(
   parameter int DATA_W = IFID_W
);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        occupancy;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, occupancy
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, occupancy
   );

endinterface

// File: rtl/pipe_data_reg.sv
// Payload register: async active-low reset and synchronous clear both load
// the bubble value; clear wins over load.
module pipe_data_reg
   import pipe_pkg::*;
#(
   parameter int                DATA_W    = IFID_W,
   parameter logic [DATA_W-1:0] FLUSH_VAL = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= FLUSH_VAL;
      end else if (clear) begin
         q <= FLUSH_VAL;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register: main entry drives the outputs, an optional
// skid entry absorbs one stall so in_ready can come from a flop.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int                DATA_W    = IFID_W,
   parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
   parameter bit                SKID_EN   = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   pipe_stage_skid_if.slave bus
);

   occ_e              state;
   occ_e              state_nxt;
   logic              ready_q;
   logic              in_ready_w;
   logic              main_valid;
   logic              skid_valid;
   logic              up_xfer;
   logic              dn_xfer;
   logic              load_main;
   logic              load_skid;
   logic              main_from_skid;
   logic [DATA_W-1:0] main_d;
   logic [DATA_W-1:0] main_q;
   logic [DATA_W-1:0] skid_q;

   assign main_valid = (state != OCC_EMPTY);
   assign skid_valid = (state == OCC_FULL);

   // Without the skid entry a full stage can only accept while it drains.
   assign in_ready_w = SKID_EN ? ready_q : (bus.out_ready | ~main_valid);
   assign up_xfer    = bus.in_valid & in_ready_w;
   assign dn_xfer    = main_valid & bus.out_ready;

   always_comb begin
      state_nxt      = state;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      case (state)
         OCC_EMPTY: begin
            if (up_xfer) begin
               load_main = 1'b1;
               state_nxt = OCC_ONE;
            end
         end
         OCC_ONE: begin
            if (up_xfer && dn_xfer) begin
               load_main = 1'b1;
            end else if (up_xfer) begin
               if (SKID_EN) begin
                  load_skid = 1'b1;
                  state_nxt = OCC_FULL;
               end else begin
                  load_main = 1'b1;
               end
            end else if (dn_xfer) begin
               state_nxt = OCC_EMPTY;
            end
         end
         OCC_FULL: begin
            if (dn_xfer) begin
               load_main      = 1'b1;
               main_from_skid = 1'b1;
               state_nxt      = OCC_ONE;
            end
         end
         default: state_nxt = OCC_EMPTY;
      endcase
      // Flush kills everything held, including a same-cycle accept.
      if (flush) begin
         state_nxt = OCC_EMPTY;
         load_main = 1'b0;
         load_skid = 1'b0;
      end
   end

   // Control state boundary
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= OCC_EMPTY;
         ready_q <= 1'b1;
      end else begin
         state   <= state_nxt;
         ready_q <= (state_nxt != OCC_FULL);
      end
   end

   // Payload boundary: main entry
   assign main_d = main_from_skid ? skid_q : bus.in_data;

   pipe_data_reg #(
      .DATA_W    (DATA_W),
      .FLUSH_VAL (FLUSH_VAL)
   ) u_main (
      .clk   (clk),
      .reset (reset),
      .load  (load_main),
      .clear (flush),
      .d     (main_d),
      .q     (main_q)
   );

   // Payload boundary: skid entry
   if (SKID_EN) begin : g_skid
      pipe_data_reg #(
         .DATA_W    (DATA_W),
         .FLUSH_VAL (FLUSH_VAL)
      ) u_skid (
         .clk   (clk),
         .reset (reset),
         .load  (load_skid),
         .clear (flush),
         .d     (bus.in_data),
         .q     (skid_q)
      );
   end else begin : g_noskid
      logic unused_skid;
      assign unused_skid = load_skid;
      assign skid_q      = FLUSH_VAL;
   end

   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = main_valid;
   assign bus.out_data  = main_q;
   assign bus.occupancy = state;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: skid and non-skid instances share stimulus; a
// queue-based model of each stage is compared alongside table and hand checks.
module tb_pipe_stage_skid;
   import pipe_pkg::*;

   localparam logic [63:0] FV1 = 64'h0;
   localparam logic [63:0] FV0 = 64'hFFFF_0000_0000_0013;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [63:0] in_data;

   int checks;
   int errors;

   pipe_stage_skid_if #(.DATA_W(64)) bus1 ();
   pipe_stage_skid_if #(.DATA_W(64)) bus0 ();

   assign bus1.in_valid  = in_valid;
   assign bus1.in_data   = in_data;
   assign bus1.out_ready = out_ready;
   assign bus0.in_valid  = in_valid;
   assign bus0.in_data   = in_data;
   assign bus0.out_ready = out_ready;

   pipe_stage_skid #(.DATA_W(64), .FLUSH_VAL(FV1), .SKID_EN(1'b1)) dut1 (
      .clk(clk), .reset(reset), .flush(flush), .bus(bus1));
   pipe_stage_skid #(.DATA_W(64), .FLUSH_VAL(FV0), .SKID_EN(1'b0)) dut0 (
      .clk(clk), .reset(reset), .flush(flush), .bus(bus0));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: each stage is a FIFO of live entries plus the last shown word.
   logic [63:0] q1[$];
   logic [63:0] q0[$];
   logic [63:0] shown1;
   logic [63:0] shown0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         q1.delete();
         q0.delete();
         shown1 = FV1;
         shown0 = FV0;
      end else begin
         automatic bit dn1 = (q1.size() > 0) && out_ready;
         automatic bit up1 = in_valid && (q1.size() < 2);
         automatic bit dn0 = (q0.size() > 0) && out_ready;
         automatic bit up0 = in_valid && (out_ready || q0.size() == 0);
         if (flush) begin
            q1.delete();
            shown1 = FV1;
            q0.delete();
            shown0 = FV0;
         end else begin
            if (dn1) void'(q1.pop_front());
            if (up1) q1.push_back(in_data);
            if (q1.size() > 0) shown1 = q1[0];
            if (dn0) void'(q0.pop_front());
            if (up0) q0.push_back(in_data);
            if (q0.size() > 0) shown0 = q0[0];
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic check_models();
      chk("m1_out_valid", 64'(bus1.out_valid), 64'(q1.size() > 0));
      chk("m1_out_data",  bus1.out_data, shown1);
      chk("m1_occupancy", 64'(bus1.occupancy), 64'(q1.size()));
      chk("m1_in_ready",  64'(bus1.in_ready), 64'(q1.size() < 2));
      chk("m0_out_valid", 64'(bus0.out_valid), 64'(q0.size() > 0));
      chk("m0_out_data",  bus0.out_data, shown0);
      chk("m0_occupancy", 64'(bus0.occupancy), 64'(q0.size()));
      chk("m0_in_ready",  64'(bus0.in_ready), 64'(out_ready || q0.size() == 0));
   endtask

   task automatic drive(input logic iv, input logic [63:0] d, input logic ordy, input logic fl);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        iv;
      logic [63:0] d;
      logic        ordy;
      logic        fl;
      logic        e_ov;
      logic [63:0] e_od;
      logic [1:0]  e_occ;
      logic        e_ir;
   } vec_t;

   vec_t tbl[15];

   initial begin
      checks = 0;
      errors = 0;
      tbl[0]  = '{1, 64'h11, 1, 0, 1, 64'h11, 2'd1, 1};
      tbl[1]  = '{1, 64'h22, 0, 0, 1, 64'h11, 2'd2, 0};
      tbl[2]  = '{1, 64'h33, 0, 0, 1, 64'h11, 2'd2, 0};
      tbl[3]  = '{1, 64'h33, 1, 0, 1, 64'h22, 2'd1, 1};
      tbl[4]  = '{1, 64'h33, 1, 0, 1, 64'h33, 2'd1, 1};
      tbl[5]  = '{0, 64'h0,  1, 0, 0, 64'h33, 2'd0, 1};
      tbl[6]  = '{1, 64'h55, 0, 0, 1, 64'h55, 2'd1, 1};
      tbl[7]  = '{0, 64'h0,  1, 1, 0, FV1,    2'd0, 1};
      tbl[8]  = '{1, 64'h66, 0, 0, 1, 64'h66, 2'd1, 1};
      tbl[9]  = '{1, 64'h77, 0, 0, 1, 64'h66, 2'd2, 0};
      tbl[10] = '{1, 64'h44, 0, 1, 0, FV1,    2'd0, 1};
      tbl[11] = '{0, 64'h0,  1, 0, 0, FV1,    2'd0, 1};
      tbl[12] = '{1, 64'h88, 0, 0, 1, 64'h88, 2'd1, 1};
      tbl[13] = '{1, 64'h99, 0, 1, 0, FV1,    2'd0, 1};
      tbl[14] = '{0, 64'h0,  1, 0, 0, FV1,    2'd0, 1};

      // Reset held for two cycles
      reset = 1'b0;
      drive(0, 64'h0, 0, 0);
      step();
      step();
      chk("rst1_out_valid", 64'(bus1.out_valid), 64'd0);
      chk("rst1_occupancy", 64'(bus1.occupancy), 64'd0);
      chk("rst1_in_ready",  64'(bus1.in_ready), 64'd1);
      chk("rst1_out_data",  bus1.out_data, FV1);
      chk("rst0_in_ready",  64'(bus0.in_ready), 64'd1);
      chk("rst0_out_data",  bus0.out_data, FV0);
      #2 reset = 1'b1;

      // IF/ID stream with out_ready high
      for (int k = 0; k < 4; k++) begin
         automatic ifid_t p = make_ifid(32'(4 + 4 * k), 32'h2008_0005 + 32'(k));
         drive(1, p, 1, 0);
         step();
         chk("stream_out_valid", 64'(bus1.out_valid), 64'd1);
         chk("stream_out_data",  bus1.out_data, p);
         chk("stream_occupancy", 64'(bus1.occupancy), 64'd1);
         chk("stream_in_ready",  64'(bus1.in_ready), 64'd1);
      end
      drive(0, 64'h0, 1, 0);
      step();
      chk("stream_drained", 64'(bus1.out_valid), 64'd0);

      // Table: stall absorption, flush with drain, flush while full
      for (int i = 0; i < 15; i++) begin
         drive(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
         step();
         chk($sformatf("tbl%0d_out_valid", i), 64'(bus1.out_valid), 64'(tbl[i].e_ov));
         chk($sformatf("tbl%0d_out_data", i),  bus1.out_data, tbl[i].e_od);
         chk($sformatf("tbl%0d_occupancy", i), 64'(bus1.occupancy), 64'(tbl[i].e_occ));
         chk($sformatf("tbl%0d_in_ready", i),  64'(bus1.in_ready), 64'(tbl[i].e_ir));
      end

      // Async reset while full, between edges
      drive(1, 64'hA1, 0, 0);
      step();
      drive(1, 64'hA2, 0, 0);
      step();
      chk("ar_full_occ", 64'(bus1.occupancy), 64'd2);
      #2 reset = 1'b0;
      #1;
      chk("ar_out_valid", 64'(bus1.out_valid), 64'd0);
      chk("ar_occupancy", 64'(bus1.occupancy), 64'd0);
      chk("ar_in_ready",  64'(bus1.in_ready), 64'd1);
      chk("ar_out_data",  bus1.out_data, FV1);
      chk("ar0_out_data", bus0.out_data, FV0);
      #1 reset = 1'b1;
      drive(1, 64'hABC, 1, 0);
      #1;
      chk("ar_no_early", 64'(bus1.out_valid), 64'd0);
      step();
      chk("ar_lat_valid", 64'(bus1.out_valid), 64'd1);
      chk("ar_lat_data",  bus1.out_data, 64'hABC);

      // Non-skid instance: combinational ready, accept with drain
      drive(0, 64'h0, 1, 1);
      step();
      drive(1, 64'hD0, 1, 0);
      step();
      chk("ns_out_data",  bus0.out_data, 64'hD0);
      chk("ns_occupancy", 64'(bus0.occupancy), 64'd1);
      drive(1, 64'hE0, 0, 0);
      #1;
      chk("ns_ready_low", 64'(bus0.in_ready), 64'd0);
      drive(1, 64'hE0, 1, 0);
      #1;
      chk("ns_ready_high", 64'(bus0.in_ready), 64'd1);
      step();
      chk("ns_pass_data", bus0.out_data, 64'hE0);
      chk("ns_pass_occ",  64'(bus0.occupancy), 64'd1);
      check_models();

      // Randomized traffic against the queue model
      for (int c = 0; c < 400; c++) begin
         @(posedge clk);
         #1;
         drive(1'($urandom_range(0, 9) < 7), {$urandom, $urandom},
               1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 15) == 0));
         #1;
         check_models();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
